// File: rtl/mem_data_pkg.sv
// Shared types and helpers for the mem_data access controller.
// The controller's optional round-robin arbitration is enabled with MEM_DATA_CTRL_RR_EN.
package mem_data_pkg;

  localparam int NPORTS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_RSP = 2'd1,
    RMW_WR = 2'd2,
    WR_RSP = 2'd3
  } mem_ctrl_state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] data,
                                           input logic [3:0]  be,
                                           input logic [31:0] old);
    logic [31:0] merged;
    merged = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = data[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_data_arb.sv
// 2-way request arbiter; grant is combinational from valids (and pointer).
// MEM_DATA_CTRL_RR_EN selects round-robin, otherwise port 0 has fixed priority.
module mem_data_arb (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

`ifdef MEM_DATA_CTRL_RR_EN
  logic r_ptr;

  // Pointer names the favoured port; after serving port 0 it favours port 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= 1'b0;
    end else if (accept) begin
      r_ptr <= grant[0];
    end
  end

  assign grant[0] = valid[0] & (~r_ptr | ~valid[1]);
  assign grant[1] = valid[1] & ( r_ptr | ~valid[0]);
`else
  logic w_unused;
  assign w_unused = ^{clk_i, rst_ni, accept};

  assign grant[0] = valid[0];
  assign grant[1] = valid[1] & ~valid[0];
`endif

endmodule

// File: rtl/mem_data_ctrl.sv
// Two-port controller for mem_data: arbitration, read sequencing, byte-enable RMW.
// Arbitration mode chosen by MEM_DATA_CTRL_RR_EN (round-robin) or fixed priority.
module mem_data_ctrl (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0]       req_we_i,
  input  logic [1:0][31:0] req_addr_i,
  input  logic [1:0][3:0]  req_be_i,
  input  logic [1:0][31:0] req_wdata_i,
  output logic [1:0]       rsp_valid_o,
  output logic [31:0]      rsp_rdata_o,
  output logic [31:0]      mem_addr_r_o,
  input  logic [31:0]      mem_data_r_i,
  output logic             mem_wr_en_o,
  output logic [31:0]      mem_addr_w_o,
  output logic [31:0]      mem_data_w_o
);
  import mem_data_pkg::*;

  mem_ctrl_state_e r_state;
  logic            r_port;
  logic [31:0]     r_addr;
  logic [3:0]      r_be;
  logic [31:0]     r_wdata;
  logic [1:0]      r_rsp_vld;
  logic            r_rmw_wr;

  logic [1:0]  w_grant;
  logic [1:0]  w_ready;
  logic        w_accept;
  logic        w_sel;
  logic [31:0] w_addr;
  logic        w_we;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_full_wr;
  logic        w_unused;

  mem_data_arb u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid  (req_valid_i & {NPORTS{r_state == IDLE}}),
    .accept (w_accept),
    .grant  (w_grant)
  );

  // Ready is gated by reset so nothing is accepted while the block is held.
  assign w_ready   = w_grant & {NPORTS{rst_ni}};
  assign w_accept  = |w_ready;
  assign w_sel     = w_ready[1];
  assign w_addr    = {req_addr_i[w_sel][31:2], 2'b00};
  assign w_we      = req_we_i[w_sel];
  assign w_be      = req_be_i[w_sel];
  assign w_wdata   = req_wdata_i[w_sel];
  assign w_full_wr = w_accept & w_we & (w_be == 4'hF);
  assign w_unused  = ^{req_addr_i[0][1:0], req_addr_i[1][1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_port    <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rsp_vld <= '0;
      r_rmw_wr  <= 1'b0;
    end else begin
      r_rsp_vld <= '0;
      r_rmw_wr  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_port  <= w_sel;
            r_addr  <= w_addr;
            r_be    <= w_be;
            r_wdata <= w_wdata;
            if (!w_we) begin
              r_state          <= RD_RSP;
              r_rsp_vld[w_sel] <= 1'b1;
            end else if (w_be == 4'hF || w_be == 4'h0) begin
              r_state          <= WR_RSP;
              r_rsp_vld[w_sel] <= 1'b1;
            end else begin
              r_state  <= RMW_WR;
              r_rmw_wr <= 1'b1;
            end
          end
        end
        RMW_WR: begin
          r_state           <= WR_RSP;
          r_rsp_vld[r_port] <= 1'b1;
        end
        RD_RSP:  r_state <= IDLE;
        WR_RSP:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = w_ready;
  assign rsp_valid_o  = r_rsp_vld;
  assign rsp_rdata_o  = (r_state == RD_RSP) ? mem_data_r_i : '0;
  assign mem_addr_r_o = w_accept ? w_addr : r_addr;
  assign mem_wr_en_o  = w_full_wr | r_rmw_wr;
  assign mem_addr_w_o = w_full_wr ? w_addr : r_addr;
  // Old bytes arrive from the read issued on the accept cycle.
  assign mem_data_w_o = w_full_wr ? w_wdata :
                        r_rmw_wr  ? be_merge(r_wdata, r_be, mem_data_r_i) : r_wdata;

endmodule

// File: tb/tb_mem_data_ctrl.sv
// Scoreboard bench for mem_data_ctrl with a registered-read memory model.
// Arbitration expectations follow MEM_DATA_CTRL_RR_EN.
module tb_mem_data_ctrl;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready_o;
  logic [1:0]       req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][3:0]  req_be;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid_o;
  logic [31:0]      rsp_rdata_o;
  logic [31:0]      mem_addr_r_o;
  logic [31:0]      mem_data_r;
  logic             mem_wr_en_o;
  logic [31:0]      mem_addr_w_o;
  logic [31:0]      mem_data_w_o;

  logic [31:0] mem [0:63];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int          port;
    logic        rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  mem_data_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_be_i     (req_be),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .mem_addr_r_o (mem_addr_r_o),
    .mem_data_r_i (mem_data_r),
    .mem_wr_en_o  (mem_wr_en_o),
    .mem_addr_w_o (mem_addr_w_o),
    .mem_data_w_o (mem_data_w_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    mem_data_r <= mem[mem_addr_r_o[7:2]];
    if (mem_wr_en_o) mem[mem_addr_w_o[7:2]] <= mem_data_w_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_o != 2'b00) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b expected none (cycle %0d)", rsp_valid_o, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_port", {30'd0, rsp_valid_o}, 32'd1 << e.port);
        chk("rsp_cycle", cyc, e.cyc);
        if (e.rd) chk("rsp_rdata", rsp_rdata_o, e.data);
      end
    end
  end

  task automatic issue(input int p, input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input int lat, input bit push);
    bit got;
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    req_addr[p]  = addr;
    req_be[p]    = be;
    req_wdata[p] = wd;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (req_ready_o[p]) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no ready for port %0d expected ready", p);
    end else begin
      chk("wr_en_at_accept", {31'd0, mem_wr_en_o}, {31'd0, (we && be == 4'hF)});
      chk("addr_r_at_accept", mem_addr_r_o, {addr[31:2], 2'b00});
      if (push) sbq.push_back('{port: p, rd: !we, data: exp_rd, cyc: cyc + lat});
    end
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_w;
    bit got;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[8'h20 >> 2] = 32'h11223344;
    mem[8'h30 >> 2] = 32'hCAFEF00D;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;

    // Held in reset with requests pending: everything must stay quiet.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {30'd0, req_ready_o}, 32'd0);
    chk("reset_rsp_valid", {30'd0, rsp_valid_o}, 32'd0);
    chk("reset_wr_en", {31'd0, mem_wr_en_o}, 32'd0);
    chk("reset_rdata", rsp_rdata_o, 32'd0);
    req_valid = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full write then read-back.
    issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'd0, 1, 1'b1);
    chk("full_wr_mem", mem[8'h10 >> 2], 32'hDEADBEEF);
    issue(0, 1'b0, 32'h10, 4'h0, 32'd0, 32'hDEADBEEF, 1, 1'b1);

    // Partial write merges into the old word one cycle after accept.
    issue(1, 1'b1, 32'h20, 4'b0010, 32'h0000AA00, 32'd0, 2, 1'b1);
    @(negedge clk);
    chk("rmw_wr_en", {31'd0, mem_wr_en_o}, 32'd1);
    chk("rmw_data_w", mem_data_w_o, 32'h1122AA44);
    chk("rmw_addr_w", mem_addr_w_o, 32'h20);
    @(posedge clk);
    #1;
    chk("rmw_mem", mem[8'h20 >> 2], 32'h1122AA44);
    issue(1, 1'b0, 32'h20, 4'h0, 32'd0, 32'h1122AA44, 1, 1'b1);

    // Zero byte-enable write: acknowledged but never written.
    issue(0, 1'b1, 32'h24, 4'b0000, 32'hFFFFFFFF, 32'd0, 1, 1'b1);
    @(negedge clk);
    chk("be0_wr_en_next", {31'd0, mem_wr_en_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("be0_mem", mem[8'h24 >> 2], 32'd0);

    // Low address bits are ignored.
    issue(1, 1'b0, 32'h13, 4'h0, 32'd0, 32'hDEADBEEF, 1, 1'b1);

    // Reset lands during the write-back cycle of a partial write.
    issue(0, 1'b1, 32'h30, 4'b0001, 32'h000000FF, 32'd0, 2, 1'b0);
    chk("rmw_pre_reset_wr_en", {31'd0, mem_wr_en_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_en", {31'd0, mem_wr_en_o}, 32'd0);
    chk("rst_mid_rsp_valid", {30'd0, rsp_valid_o}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_mid_mem", mem[8'h30 >> 2], 32'hCAFEF00D);

    // Both ports continuously valid for six reads.
    req_we    = 2'b00;
    req_addr[0] = 32'h10;
    req_addr[1] = 32'h20;
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        if (req_ready_o != 2'b00) got = 1'b1;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL arb_timeout: got no ready expected grant %0d", k);
        break;
      end
`ifdef MEM_DATA_CTRL_RR_EN
      exp_w = k % 2;
`else
      exp_w = 0;
`endif
      chk("arb_grant", {30'd0, req_ready_o}, 32'd1 << exp_w);
      sbq.push_back('{port: exp_w, rd: 1'b1,
                      data: (exp_w == 0) ? 32'hDEADBEEF : 32'h1122AA44, cyc: cyc + 1});
      @(posedge clk);
      #1;
    end
    req_valid = 2'b00;

    // The aborted write-back must not have disturbed the word.
    issue(1, 1'b0, 32'h30, 4'h0, 32'd0, 32'hCAFEF00D, 1, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
